ni_gen2: RTL

Second-generation GPU network interface, one per GPU endpoint, between a GPU and its leaf router.
- Translates GPU destination IDs into routing headers on the TX path.
- Filters and reverse-translates headers on the RX path.
- Both directions are parametrised FIFOs with full valid/ready handshakes, including backpressure toward the router.
- Saturating counters record dropped traffic.

---
 rtl/ni_gen2.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ni_gen2.sv
// GPU network interface: TX ID->address translation, RX address filtering, drop counters.
// Build option NI_LOOPBACK_EN: TX flits addressed to this GPU go straight into the RX FIFO.
module ni_gen2 #(
  parameter int unsigned GPU_ID      = 15,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned HEADER_W    = 6,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned MAX_GPU     = 32,
  parameter int unsigned ADDR_OFFSET = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] gpu_data_in,
  input  logic              gpu_valid_in,
  output logic              gpu_ready_out,
  output logic [DATA_W-1:0] gpu_data_out,
  output logic              gpu_valid_out,
  input  logic              gpu_ready_in,
  output logic [DATA_W-1:0] router_data_out,
  output logic              router_valid_out,
  input  logic              router_ready_in,
  input  logic [DATA_W-1:0] router_data_in,
  input  logic              router_valid_in,
  output logic              router_ready_out,
  output logic [CNT_W-1:0]  tx_drop_cnt,
  output logic [CNT_W-1:0]  rx_misroute_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PAY_W = DATA_W - HEADER_W;
  localparam logic [HEADER_W-1:0] OWN_ID   = HEADER_W'(GPU_ID);
  localparam logic [HEADER_W-1:0] OWN_ADDR = HEADER_W'(GPU_ID + ADDR_OFFSET);
  localparam logic [HEADER_W-1:0] OFFSET   = HEADER_W'(ADDR_OFFSET);
  localparam logic [PTR_W:0]      FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0]   r_tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_tx_wptr, r_tx_rptr;
  logic [PTR_W:0]      r_tx_cnt;
  logic [DATA_W-1:0]   r_router_data;
  logic                r_router_valid;

  logic [DATA_W-1:0]   r_rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_rx_wptr, r_rx_rptr;
  logic [PTR_W:0]      r_rx_cnt;
  logic [DATA_W-1:0]   r_gpu_data;
  logic                r_gpu_valid;

  logic [CNT_W-1:0]    r_tx_drop_cnt, r_rx_mis_cnt;

  logic [HEADER_W-1:0] w_tx_id;
  logic [PAY_W-1:0]    w_tx_payload;
  logic                w_tx_id_ok, w_tx_loop, w_tx_full, w_rx_full;
  logic                w_tx_acc, w_tx_push, w_tx_drop, w_tx_pop, w_loop_push;
  logic                w_rx_acc, w_rx_hit, w_rx_push_rtr, w_rx_push, w_rx_drop, w_rx_pop;
  logic [DATA_W-1:0]   w_tx_wdata, w_rx_wdata;

  assign w_tx_id      = gpu_data_in[DATA_W-1 -: HEADER_W];
  assign w_tx_payload = gpu_data_in[PAY_W-1:0];
  assign w_tx_id_ok   = (w_tx_id != '0) && (32'(w_tx_id) <= MAX_GPU);
  assign w_tx_full    = (r_tx_cnt == FULL_CNT);
  assign w_rx_full    = (r_rx_cnt == FULL_CNT);

`ifdef NI_LOOPBACK_EN
  // Router owns the RX write port; a loopback flit waits for a cycle with no router flit.
  assign w_tx_loop     = (w_tx_id == OWN_ID);
  assign gpu_ready_out = w_tx_loop ? (!w_rx_full && !router_valid_in) : !w_tx_full;
`else
  assign w_tx_loop     = 1'b0;
  assign gpu_ready_out = !w_tx_full;
`endif

  assign w_tx_acc    = gpu_valid_in && gpu_ready_out;
  assign w_tx_push   = w_tx_acc && w_tx_id_ok && !w_tx_loop;
  assign w_tx_drop   = w_tx_acc && !w_tx_id_ok && !w_tx_loop;
  assign w_loop_push = w_tx_acc && w_tx_loop;
  assign w_tx_wdata  = {w_tx_id + OFFSET, w_tx_payload};
  assign w_tx_pop    = (r_tx_cnt != '0) && (!r_router_valid || router_ready_in);

  assign router_ready_out = !w_rx_full;
  assign w_rx_acc      = router_valid_in && router_ready_out;
  assign w_rx_hit      = (router_data_in[DATA_W-1 -: HEADER_W] == OWN_ADDR);
  assign w_rx_push_rtr = w_rx_acc && w_rx_hit;
  assign w_rx_drop     = w_rx_acc && !w_rx_hit;
  assign w_rx_push     = w_rx_push_rtr || w_loop_push;
  assign w_rx_wdata    = {OWN_ID, w_rx_push_rtr ? router_data_in[PAY_W-1:0] : w_tx_payload};
  assign w_rx_pop      = (r_rx_cnt != '0) && (!r_gpu_valid || gpu_ready_in);

  assign router_data_out  = r_router_data;
  assign router_valid_out = r_router_valid;
  assign gpu_data_out     = r_gpu_data;
  assign gpu_valid_out    = r_gpu_valid;
  assign tx_drop_cnt      = r_tx_drop_cnt;
  assign rx_misroute_cnt  = r_rx_mis_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_tx_mem[i] <= '0;
      r_tx_wptr      <= '0;
      r_tx_rptr      <= '0;
      r_tx_cnt       <= '0;
      r_router_data  <= '0;
      r_router_valid <= 1'b0;
    end else begin
      if (w_tx_push) begin
        r_tx_mem[r_tx_wptr] <= w_tx_wdata;
        r_tx_wptr           <= r_tx_wptr + PTR_W'(1);
      end
      if (w_tx_pop) begin
        r_router_data  <= r_tx_mem[r_tx_rptr];
        r_router_valid <= 1'b1;
        r_tx_rptr      <= r_tx_rptr + PTR_W'(1);
      end else if (router_ready_in) begin
        r_router_valid <= 1'b0;
      end
      r_tx_cnt <= r_tx_cnt + (PTR_W+1)'(w_tx_push) - (PTR_W+1)'(w_tx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_rx_mem[i] <= '0;
      r_rx_wptr   <= '0;
      r_rx_rptr   <= '0;
      r_rx_cnt    <= '0;
      r_gpu_data  <= '0;
      r_gpu_valid <= 1'b0;
    end else begin
      if (w_rx_push) begin
        r_rx_mem[r_rx_wptr] <= w_rx_wdata;
        r_rx_wptr           <= r_rx_wptr + PTR_W'(1);
      end
      if (w_rx_pop) begin
        r_gpu_data  <= r_rx_mem[r_rx_rptr];
        r_gpu_valid <= 1'b1;
        r_rx_rptr   <= r_rx_rptr + PTR_W'(1);
      end else if (gpu_ready_in) begin
        r_gpu_valid <= 1'b0;
      end
      r_rx_cnt <= r_rx_cnt + (PTR_W+1)'(w_rx_push) - (PTR_W+1)'(w_rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_drop_cnt <= '0;
      r_rx_mis_cnt  <= '0;
    end else begin
      if (w_tx_drop && (r_tx_drop_cnt != '1)) r_tx_drop_cnt <= r_tx_drop_cnt + CNT_W'(1);
      if (w_rx_drop && (r_rx_mis_cnt != '1))  r_rx_mis_cnt  <= r_rx_mis_cnt + CNT_W'(1);
    end
  end

endmodule
